seg7_scan_driver: RTL and testbench

Time-multiplexed 4-digit seven-segment driver. It is the distribution end of the shared segment bus: one common segment bus is fanned out to four digits by cycling active-low anode selects at a divided refresh rate. A LOAD handshake captures a new 16-bit hex value plus per-digit dot/blank masks. The new value is committed only at a frame boundary, so a frame never tears.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scan_driver.sv | 113 +++++++++++
 tb/tb_seg7_scan_driver.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment bytes are active-low {DP,G,F,E,D,C,B,A}.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam int unsigned SEG_DP = 7;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_A  = 0;

    // Active-low {G..A} glyphs for hex digits 0..F.
    localparam logic [6:0] HEX_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dots;
        logic [3:0]  blank;
    } disp_t;

    typedef enum logic [1:0] {
        StDigit0,
        StDigit1,
        StDigit2,
        StDigit3
    } digit_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load-side inputs and display-side outputs of the seven-segment scan driver.
// The master drives LOAD/VALUE/DOTS/BLANK; the driver is the slave.
interface seg7_scan_driver_if;

    logic        LOAD;
    logic [15:0] VALUE;
    logic [3:0]  DOTS;
    logic [3:0]  BLANK;
    logic [3:0]  SEG_SELECT;
    logic [7:0]  HEX_OUT;
    logic        FRAME_DONE;
    logic        PENDING;

    modport master (
        output LOAD, VALUE, DOTS, BLANK,
        input  SEG_SELECT, HEX_OUT, FRAME_DONE, PENDING
    );

    modport slave (
        input  LOAD, VALUE, DOTS, BLANK,
        output SEG_SELECT, HEX_OUT, FRAME_DONE, PENDING
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {G..A} segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_PATTERNS[digit_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-aligned value commit.
// Each digit slot is CLK_DIV cycles, the last of which blanks all anodes.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned CNT_WIDTH = $clog2(CLK_DIV)
) (
    input  logic              CLK,
    input  logic              RESETN,
    seg7_scan_driver_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] PRESC_MAX = CNT_WIDTH'(CLK_DIV - 1);

    logic [CNT_WIDTH-1:0] presc_q, presc_d;
    digit_e               idx_q, idx_d;
    disp_t                disp_q, disp_d;
    disp_t                pend_q, pend_d;
    logic                 pend_flag_q, pend_flag_d;
    logic [3:0]           sel_q, sel_d;
    logic [7:0]           hex_q, hex_d;
    logic                 fd_q, fd_d;

    disp_t      load_val;
    logic       tick;
    logic       boundary;
    logic [3:0] nibble;
    logic [6:0] seg_pat;

    assign load_val = {bus.VALUE, bus.DOTS, bus.BLANK};
    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (idx_q == StDigit3);
    assign nibble   = disp_q.value[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_decode (
        .digit_i (nibble),
        .seg_o   (seg_pat)
    );

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            unique case (idx_q)
                StDigit0: idx_d = StDigit1;
                StDigit1: idx_d = StDigit2;
                StDigit2: idx_d = StDigit3;
                StDigit3: idx_d = StDigit0;
            endcase
        end
    end

    always_comb begin
        presc_d     = tick ? '0 : presc_q + CNT_WIDTH'(1);
        sel_d       = ANODE_OFF;
        hex_d       = SEG_OFF;
        fd_d        = boundary;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;

        // Outputs reflect the pre-edge slot; the tick cycle is a ghost-suppression blank.
        if (!tick) begin
            sel_d = ~(4'b0001 << idx_q);
            if (!disp_q.blank[idx_q]) begin
                hex_d[SEG_DP]      = ~disp_q.dots[idx_q];
                hex_d[SEG_G:SEG_A] = seg_pat;
            end
        end

        // A LOAD coinciding with the boundary bypasses the pending stage entirely.
        if (boundary) begin
            if (bus.LOAD) begin
                disp_d      = load_val;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                disp_d      = pend_q;
                pend_flag_d = 1'b0;
            end
        end else if (bus.LOAD) begin
            pend_d      = load_val;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            presc_q     <= '0;
            idx_q       <= StDigit0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            sel_q       <= ANODE_OFF;
            hex_q       <= SEG_OFF;
            fd_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            sel_q       <= sel_d;
            hex_q       <= hex_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.SEG_SELECT = sel_q;
    assign bus.HEX_OUT    = hex_q;
    assign bus.FRAME_DONE = fd_q;
    assign bus.PENDING    = pend_flag_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: cycle-count reference model plus directed frames.
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK = ~CLK;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .CLK_DIV (DIV)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] ref_pat [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: position derived from edges counted since reset.
    int          cyc     = 0;
    logic [23:0] shown   = '0;
    logic [23:0] pend_v  = '0;
    logic        pend_f  = 1'b0;
    logic [3:0]  exp_seg = 4'hF;
    logic [7:0]  exp_hex = 8'hFF;
    logic        exp_fd  = 1'b0;
    int          m_slot;
    logic        m_tick;
    logic [23:0] in_vec;
    logic [13:0] obs, expv;

    assign m_slot = (cyc / DIV) % 4;
    assign m_tick = ((cyc % DIV) == DIV - 1);
    assign in_vec = {bus.VALUE, bus.DOTS, bus.BLANK};
    assign obs    = {bus.SEG_SELECT, bus.HEX_OUT, bus.FRAME_DONE, bus.PENDING};
    assign expv   = {exp_seg, exp_hex, exp_fd, pend_f};

    function automatic logic [7:0] ref_hex(input logic [23:0] d, input int s);
        logic [15:0] v;
        logic [3:0]  dots;
        logic [3:0]  blank;
        v     = d[23:8];
        dots  = d[7:4];
        blank = d[3:0];
        if (blank[s]) return 8'hFF;
        return {~dots[s], ref_pat[v[s*4 +: 4]]};
    endfunction

    always @(posedge CLK) begin
        if (!RESETN) begin
            cyc     <= 0;
            shown   <= '0;
            pend_v  <= '0;
            pend_f  <= 1'b0;
            exp_seg <= 4'hF;
            exp_hex <= 8'hFF;
            exp_fd  <= 1'b0;
        end else begin
            exp_seg <= m_tick ? 4'hF : ~(4'b0001 << m_slot);
            exp_hex <= m_tick ? 8'hFF : ref_hex(shown, m_slot);
            exp_fd  <= m_tick && (m_slot == 3);
            if (m_tick && m_slot == 3) begin
                if (bus.LOAD) begin
                    shown  <= in_vec;
                    pend_f <= 1'b0;
                end else if (pend_f) begin
                    shown  <= pend_v;
                    pend_f <= 1'b0;
                end
            end else if (bus.LOAD) begin
                pend_v <= in_vec;
                pend_f <= 1'b1;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic wait_mod(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (cyc % FRAME == p) return;
            @(negedge CLK);
        end
    endtask

    task automatic load_once(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.LOAD  = 1'b1;
        bus.VALUE = v;
        bus.DOTS  = d;
        bus.BLANK = b;
        @(negedge CLK);
        bus.LOAD  = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] rst_exp = {4'hF, 8'hFF, 2'b00};
        RESETN = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            total++;
            if (obs !== rst_exp) begin
                bad++;
                $display("FAIL reset_hold got=%h want=%h", obs, rst_exp);
            end
        end
        RESETN = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_run got=%h want=%h", obs, expv);
            end
        end
        RESETN = 1'b0;
        @(negedge CLK);
        total++;
        if (obs !== rst_exp) begin
            bad++;
            $display("FAIL reset_midframe got=%h want=%h", obs, rst_exp);
        end
        RESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] want_sel;
            @(negedge CLK);
            want_sel = (i == 3) ? 4'hF : 4'hE;
            total++;
            if (bus.SEG_SELECT !== want_sel || bus.HEX_OUT !== ((i == 3) ? 8'hFF : 8'hC0)) begin
                bad++;
                $display("FAIL reset_restart[%0d] got=%h/%h want=%h", i, bus.SEG_SELECT,
                         bus.HEX_OUT, want_sel);
            end
        end
    endtask

    task automatic test_timing();
        int fd_cnt    = 0;
        int blank_cnt = 0;
        logic [3:0] prev_sel;
        prev_sel = bus.SEG_SELECT;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL timing_model got=%h want=%h", obs, expv);
            end
            if (bus.FRAME_DONE === 1'b1) begin
                fd_cnt++;
                total++;
                if (prev_sel !== 4'h7 || bus.SEG_SELECT !== 4'hF) begin
                    bad++;
                    $display("FAIL timing_fd_align got=%h->%h want=7->f", prev_sel,
                             bus.SEG_SELECT);
                end
            end
            if (bus.SEG_SELECT === 4'hF) blank_cnt++;
            prev_sel = bus.SEG_SELECT;
        end
        total++;
        if (fd_cnt != 4) begin
            bad++;
            $display("FAIL timing_fd_count got=%0d want=4", fd_cnt);
        end
        total++;
        if (blank_cnt != 16) begin
            bad++;
            $display("FAIL timing_blank_count got=%0d want=16", blank_cnt);
        end
    endtask

    task automatic test_load_commit();
        logic [7:0] want [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        bit seen = 0;
        int left = 0;
        wait_mod(5);
        load_once(16'h1234, 4'h0, 4'h0);
        total++;
        if (bus.PENDING !== 1'b1) begin
            bad++;
            $display("FAIL commit_pending_rise got=%b want=1", bus.PENDING);
        end
        for (int i = 0; i < 40 && !(seen && left == 0); i++) begin
            @(negedge CLK);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL commit_model got=%h want=%h", obs, expv);
            end
            if (!seen) begin
                total++;
                if (bus.FRAME_DONE === 1'b1) begin
                    seen = 1;
                    left = FRAME;
                    if (bus.PENDING !== 1'b0) begin
                        bad++;
                        $display("FAIL commit_pending_clear got=%b want=0", bus.PENDING);
                    end
                end else if (bus.PENDING !== 1'b1) begin
                    bad++;
                    $display("FAIL commit_pending_hold got=%b want=1", bus.PENDING);
                end
            end else begin
                left--;
                for (int s = 0; s < 4; s++) begin
                    if (bus.SEG_SELECT == ~(4'b0001 << s)) begin
                        total++;
                        if (bus.HEX_OUT !== want[s]) begin
                            bad++;
                            $display("FAIL commit_digit%0d got=%h want=%h", s, bus.HEX_OUT,
                                     want[s]);
                        end
                    end
                end
            end
        end
        total++;
        if (!seen || left != 0) begin
            bad++;
            $display("FAIL commit_timeout got=seen%0d/left%0d want=seen1/left0", seen, left);
        end
    endtask

    task automatic test_last_wins();
        logic [7:0] want [4] = '{8'hC0, 8'hC0, 8'h8E, 8'hC0};
        bit seen = 0;
        int left = 0;
        wait_mod(2);
        load_once(16'hAAAA, 4'h0, 4'h0);
        wait_mod(8);
        load_once(16'h0F00, 4'h0, 4'h0);
        for (int i = 0; i < 40 && !(seen && left == 0); i++) begin
            @(negedge CLK);
            total++;
            if (obs !== expv || bus.HEX_OUT === 8'h88) begin
                bad++;
                $display("FAIL lastwins_model got=%h want=%h", obs, expv);
            end
            if (!seen) begin
                if (bus.FRAME_DONE === 1'b1) begin
                    seen = 1;
                    left = FRAME;
                end
            end else begin
                left--;
                for (int s = 0; s < 4; s++) begin
                    if (bus.SEG_SELECT == ~(4'b0001 << s)) begin
                        total++;
                        if (bus.HEX_OUT !== want[s]) begin
                            bad++;
                            $display("FAIL lastwins_digit%0d got=%h want=%h", s, bus.HEX_OUT,
                                     want[s]);
                        end
                    end
                end
            end
        end
        total++;
        if (!seen || left != 0) begin
            bad++;
            $display("FAIL lastwins_timeout got=seen%0d/left%0d want=seen1/left0", seen, left);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [3:0]  d, b;
        logic [23:0] vec;
        v   = 16'($urandom);
        d   = 4'($urandom);
        b   = 4'($urandom) & 4'b0101;
        vec = {v, d, b};
        wait_mod(15);
        load_once(v, d, b);
        total++;
        if (bus.FRAME_DONE !== 1'b1 || bus.PENDING !== 1'b0) begin
            bad++;
            $display("FAIL collide_edge got=fd%b/pend%b want=fd1/pend0", bus.FRAME_DONE,
                     bus.PENDING);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK);
            total++;
            if (obs !== expv || bus.PENDING !== 1'b0) begin
                bad++;
                $display("FAIL collide_model got=%h want=%h", obs, expv);
            end
            for (int s = 0; s < 4; s++) begin
                if (bus.SEG_SELECT == ~(4'b0001 << s)) begin
                    total++;
                    if (bus.HEX_OUT !== ref_hex(vec, s)) begin
                        bad++;
                        $display("FAIL collide_digit%0d got=%h want=%h", s, bus.HEX_OUT,
                                 ref_hex(vec, s));
                    end
                end
            end
        end
    endtask

    task automatic test_masks();
        logic [7:0] want [4] = '{8'h40, 8'hC0, 8'hC0, 8'hFF};
        bit seen  = 0;
        int left  = 0;
        int lit3  = 0;
        wait_mod(3);
        load_once(16'h8000, 4'b0001, 4'b1000);
        for (int i = 0; i < 40 && !(seen && left == 0); i++) begin
            @(negedge CLK);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL masks_model got=%h want=%h", obs, expv);
            end
            if (!seen) begin
                if (bus.FRAME_DONE === 1'b1) begin
                    seen = 1;
                    left = FRAME;
                end
            end else begin
                left--;
                if (bus.SEG_SELECT === 4'b0111) lit3++;
                for (int s = 0; s < 4; s++) begin
                    if (bus.SEG_SELECT == ~(4'b0001 << s)) begin
                        total++;
                        if (bus.HEX_OUT !== want[s]) begin
                            bad++;
                            $display("FAIL masks_digit%0d got=%h want=%h", s, bus.HEX_OUT,
                                     want[s]);
                        end
                    end
                end
            end
        end
        total++;
        if (!seen || left != 0 || lit3 != DIV - 1) begin
            bad++;
            $display("FAIL masks_frame got=seen%0d/lit3=%0d want=seen1/lit3=%0d", seen, lit3,
                     DIV - 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_model[%0d] got=%h want=%h", i, obs, expv);
            end
            RESETN    = (i != 150);
            bus.LOAD  = ($urandom_range(0, 5) == 0);
            bus.VALUE = 16'($urandom);
            bus.DOTS  = 4'($urandom);
            bus.BLANK = 4'($urandom) & 4'($urandom);
        end
        bus.LOAD = 1'b0;
        RESETN   = 1'b1;
        @(negedge CLK);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL random_tail got=%h want=%h", obs, expv);
        end
    endtask

    initial begin
        bus.LOAD  = 1'b0;
        bus.VALUE = '0;
        bus.DOTS  = '0;
        bus.BLANK = '0;
        test_reset();
        test_timing();
        test_load_commit();
        test_last_wins();
        test_back_to_back();
        test_masks();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
